// File: rtl/biriscv_run_ctrl.sv
// Benchmark run sequencer: holds the core in reset, releases it on start, counts run cycles,
// strobes progress and ends the run on a sustained halt PC or on timeout. All outputs registered.
module biriscv_run_ctrl #(
  parameter int unsigned     RESET_CYCLES    = 16,
  parameter int unsigned     PROGRESS_PERIOD = 100000,
  parameter longint unsigned TIMEOUT_CYCLES  = 64'h1_0000_0000,
  parameter logic [31:0]     HALT_PC         = 32'h0,
  parameter int unsigned     HALT_HOLD       = 4,
  parameter int              CNT_W           = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      pc0_i,
  input  logic [31:0]      pc1_i,
  output logic             core_rst_o,
  output logic             running_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             progress_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  localparam int RST_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int HOLD_W = (HALT_HOLD > 1) ? $clog2(HALT_HOLD) : 1;
  localparam int PROG_W = (PROGRESS_PERIOD > 0) ? $clog2(PROGRESS_PERIOD + 1) : 1;

  localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(RESET_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HALT_HOLD - 1);
  localparam logic [PROG_W-1:0] PROG_LOAD = PROG_W'(PROGRESS_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit                PROG_EN   = (PROGRESS_PERIOD != 0);

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    DONE,
    TIMEOUT
  } state_t;

  state_t             state;
  logic [RST_W-1:0]   rst_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [PROG_W-1:0]  prog_cnt;

  logic hit;
  logic halt_done;
  logic at_limit;
  logic prog_tick;

  assign hit       = (pc0_i == HALT_PC) || (pc1_i == HALT_PC);
  assign halt_done = hit && (hold_cnt == HOLD_LAST);
  assign at_limit  = (cycle_count_o == CNT_LAST);
  // prog_cnt counts the increments left until the count reaches the next multiple of the period
  assign prog_tick = PROG_EN && (prog_cnt == PROG_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      core_rst_o    <= 1'b1;
      running_o     <= 1'b0;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
      progress_o    <= 1'b0;
      cycle_count_o <= '0;
      rst_cnt       <= '0;
      hold_cnt      <= '0;
      prog_cnt      <= '0;
    end else begin
      progress_o <= 1'b0;
      case (state)
        IDLE, DONE, TIMEOUT: begin
          if (start_i) begin
            state         <= RESET;
            rst_cnt       <= RST_LOAD;
            cycle_count_o <= '0;
            core_rst_o    <= 1'b1;
            running_o     <= 1'b0;
            done_o        <= 1'b0;
            timeout_o     <= 1'b0;
          end
        end
        RESET: begin
          if (rst_cnt == '0) begin
            state      <= RUN;
            core_rst_o <= 1'b0;
            running_o  <= 1'b1;
            hold_cnt   <= '0;
            prog_cnt   <= PROG_LOAD;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        RUN: begin
          cycle_count_o <= cycle_count_o + 1'b1;
          hold_cnt      <= hit ? hold_cnt + 1'b1 : '0;
          // halt completion takes priority over a coincident timeout
          if (halt_done) begin
            state      <= DONE;
            core_rst_o <= 1'b1;
            running_o  <= 1'b0;
            done_o     <= 1'b1;
          end else if (at_limit) begin
            state      <= TIMEOUT;
            core_rst_o <= 1'b1;
            running_o  <= 1'b0;
            timeout_o  <= 1'b1;
          end else if (prog_tick) begin
            progress_o <= 1'b1;
            prog_cnt   <= PROG_LOAD;
          end else begin
            prog_cnt <= prog_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_biriscv_run_ctrl.sv
// Scoreboarded bench: the driver predicts each next-cycle output set from a behavioural model,
// a negedge monitor pops and compares against the run controller.
module tb_biriscv_run_ctrl;

  localparam int          RC  = 4;
  localparam int          PP  = 10;
  localparam int          TO  = 100;
  localparam int          HH  = 3;
  localparam logic [31:0] HPC = 32'h80000100;

  localparam int S_IDLE = 0, S_RESET = 1, S_RUN = 2, S_DONE = 3, S_TOUT = 4;

  logic        clk = 1'b0;
  logic        rst_i, start_i;
  logic [31:0] pc0_i, pc1_i;
  logic        core_rst_o, running_o, done_o, timeout_o, progress_o;
  logic [63:0] cycle_count_o;

  always #5 clk = ~clk;

  biriscv_run_ctrl #(
    .RESET_CYCLES   (RC),
    .PROGRESS_PERIOD(PP),
    .TIMEOUT_CYCLES (TO),
    .HALT_PC        (HPC),
    .HALT_HOLD      (HH),
    .CNT_W          (64)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pc0_i        (pc0_i),
    .pc1_i        (pc1_i),
    .core_rst_o   (core_rst_o),
    .running_o    (running_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .progress_o   (progress_o),
    .cycle_count_o(cycle_count_o)
  );

  typedef struct {
    int     cyc;
    logic   core_rst;
    logic   running;
    logic   done;
    logic   timeout;
    logic   progress;
    longint count;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   prog_seen = 0;

  // reference model: phase, run length, remaining reset cycles, current run of consecutive hits
  int     m_st = S_IDLE;
  longint m_cnt = 0;
  int     m_rleft = 0;
  int     m_streak = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      chk("core_rst_o", longint'(core_rst_o), longint'(mon_e.core_rst));
      chk("running_o", longint'(running_o), longint'(mon_e.running));
      chk("done_o", longint'(done_o), longint'(mon_e.done));
      chk("timeout_o", longint'(timeout_o), longint'(mon_e.timeout));
      chk("progress_o", longint'(progress_o), longint'(mon_e.progress));
      chk("cycle_count_o", longint'(cycle_count_o), mon_e.count);
    end
    if (progress_o === 1'b1) prog_seen++;
  end

  task automatic model_step(input logic r, input logic s, input logic [31:0] p0, input logic [31:0] p1);
    exp_t e;
    bit   hit;
    hit = (p0 == HPC) || (p1 == HPC);
    if (r) begin
      m_st = S_IDLE; m_cnt = 0; m_streak = 0;
    end else begin
      case (m_st)
        S_RESET: begin
          m_rleft--;
          if (m_rleft == 0) begin m_st = S_RUN; m_streak = 0; end
        end
        S_RUN: begin
          m_streak = hit ? m_streak + 1 : 0;
          m_cnt++;
          if (m_streak == HH) m_st = S_DONE;
          else if (m_cnt == TO) m_st = S_TOUT;
        end
        default: begin
          if (s) begin m_st = S_RESET; m_rleft = RC; m_cnt = 0; end
        end
      endcase
    end
    e.cyc      = cyc + 1;
    e.core_rst = (m_st != S_RUN);
    e.running  = (m_st == S_RUN);
    e.done     = (m_st == S_DONE);
    e.timeout  = (m_st == S_TOUT);
    e.progress = (m_st == S_RUN) && (m_cnt > 0) && (m_cnt % PP == 0);
    e.count    = m_cnt;
    sbq.push_back(e);
  endtask

  task automatic step(input logic r, input logic s, input logic [31:0] p0, input logic [31:0] p1);
    rst_i = r; start_i = s; pc0_i = p0; pc1_i = p1;
    model_step(r, s, p0, p1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] miss_pc();
    logic [31:0] p;
    p = $urandom;
    if (p == HPC) p = p ^ 32'h4;
    return p;
  endfunction

  // sel: 0 = hit on pc0, 1 = hit on pc1, 2 = random lane(s)
  task automatic make_pcs(input bit hit, input int sel, output logic [31:0] p0, output logic [31:0] p1);
    int lane;
    p0 = miss_pc();
    p1 = miss_pc();
    if (hit) begin
      lane = (sel == 2) ? $urandom_range(2) : sel;
      if (lane != 1) p0 = HPC;
      if (lane != 0) p1 = HPC;
    end
  endtask

  task automatic run(input logic [127:0] mask, input int sel, input int pct, input int rst_at);
    logic [31:0] p0, p1;
    bit hit;
    int n;
    n = 0;
    make_pcs(1'b0, sel, p0, p1);
    step(1'b0, 1'b1, p0, p1);
    while ((m_st == S_RESET || m_st == S_RUN) && n < 400) begin
      n++;
      if (m_st == S_RUN && m_cnt == longint'(rst_at)) begin
        make_pcs(1'b0, sel, p0, p1);
        step(1'b1, 1'b0, p0, p1);
        break;
      end
      hit = (m_st == S_RUN && m_cnt < 128 && mask[int'(m_cnt)] == 1'b1) || ($urandom_range(99) < pct);
      make_pcs(hit, sel, p0, p1);
      step(1'b0, 1'($urandom_range(1)), p0, p1);
    end
    if (n >= 400) begin
      errors++;
      $display("FAIL run_bound: got %0d cycles expected fewer than 400", n);
    end
    for (int i = 0; i < 2; i++) begin
      make_pcs(1'($urandom_range(1)), sel, p0, p1);
      step(1'b0, 1'b0, p0, p1);
    end
  endtask

  initial begin
    logic [127:0] mask;
    rst_i = 1'b1; start_i = 1'b0; pc0_i = '0; pc1_i = '0;

    // reset, then idle with start low (halt PCs present must not matter)
    step(1'b1, 1'b0, HPC, miss_pc());
    step(1'b1, 1'b1, miss_pc(), miss_pc());
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, HPC, HPC);

    // halt on pc0 at 20..22, then on pc1 only
    mask = '0; mask[22:20] = '1;
    run(mask, 0, 0, -1);
    chk("halt_pc0_count", longint'(cycle_count_o), 23);
    run(mask, 1, 0, -1);
    chk("halt_pc1_done", longint'(done_o), 1);
    chk("halt_pc1_count", longint'(cycle_count_o), 23);

    // broken streak: hits 5,6 miss 7 hits 8,9,10
    mask = '0; mask[6:5] = '1; mask[10:8] = '1;
    prog_seen = 0;
    run(mask, 0, 0, -1);
    chk("streak_count", longint'(cycle_count_o), 11);
    chk("streak_progress", longint'(prog_seen), 1);

    // never halts: timeout
    mask = '0;
    prog_seen = 0;
    run(mask, 0, 0, -1);
    chk("to_progress_pulses", longint'(prog_seen), 9);
    chk("to_timeout", longint'(timeout_o), 1);
    chk("to_done", longint'(done_o), 0);
    chk("to_count", longint'(cycle_count_o), 100);

    // halt completes on the timeout cycle: done wins
    mask = '0; mask[99:97] = '1;
    run(mask, 2, 0, -1);
    chk("tie_done", longint'(done_o), 1);
    chk("tie_timeout", longint'(timeout_o), 0);
    chk("tie_count", longint'(cycle_count_o), 100);

    // restart from DONE with random hits, then rst mid-run
    run('0, 2, 15, -1);
    run('0, 2, 0, 30);
    chk("midrst_core_rst", longint'(core_rst_o), 1);
    chk("midrst_running", longint'(running_o), 0);
    chk("midrst_count", longint'(cycle_count_o), 0);

    for (int k = 0; k < 5; k++) run('0, 2, 25, -1);

    step(1'b0, 1'b0, miss_pc(), miss_pc());
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", longint'(sbq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
